// File: rtl/twiddle_gen.sv
// ============================================================================
// Module   : twiddle_gen
// Purpose  : Full-circle FFT twiddle-factor generator. A quarter-wave cosine
//            table (N/4 entries) is expanded by quadrant symmetry into
//            W = cos(2*pi*k/N) -/+ j*sin(2*pi*k/N) for any k in 0..N-1.
//            Results come out of a 3-stage pipeline (decode, table read,
//            sign/negate). A stride sequencer emits k = 0, s, 2s, ... (mod N)
//            for a whole butterfly stage from one start pulse.
// Ports    : clk, rst (sync, active-high), hold (freeze everything)
//            in_valid/in_k/inv   : direct request (inv also taken at start)
//            start/stride/count  : sequencer launch
//            busy                : sequencer running
//            out_valid/out_k     : result strobe and its index
//            out_wr/out_wi       : signed real / imaginary parts, DW bits
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module twiddle_gen #(
  parameter int LOG2N = 10,
  parameter int DW    = 16,
  parameter int FRAC  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    in_valid,
  input  logic [LOG2N-1:0]        in_k,
  input  logic                    inv,
  input  logic                    start,
  input  logic [LOG2N-1:0]        stride,
  input  logic [LOG2N:0]          count,
  output logic                    busy,
  output logic                    out_valid,
  output logic [LOG2N-1:0]        out_k,
  output logic signed [DW-1:0]    out_wr,
  output logic signed [DW-1:0]    out_wi
);

  localparam int c_rw = LOG2N - 2;        // quarter-table address width
  localparam int c_qn = 1 << c_rw;        // quarter-table depth

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;

  // --------------------------------------------------------------------------
  // Quarter-wave table: round(2^FRAC * cos(2*pi*i/N)), i < N/4.
  // Evaluated with a Taylor series so that only basic real arithmetic is
  // needed at elaboration; the angle never exceeds pi/2, where 12 terms are
  // far below one LSB of error.
  // --------------------------------------------------------------------------
  function automatic logic [FRAC:0] cos_entry(input int idx);
    real x;
    real term;
    real sum;
    int  v;
    x    = 6.283185307179586 * real'(idx) / real'(1 << LOG2N);
    term = 1.0;
    sum  = 1.0;
    for (int n = 1; n <= 12; n++) begin
      term = -term * x * x / real'((2 * n - 1) * (2 * n));
      sum  = sum + term;
    end
    v = $rtoi(sum * real'(1 << FRAC) + 0.5);
    return (FRAC + 1)'(v);
  endfunction

  logic [FRAC:0] w_rom [c_qn];

  generate
    for (genvar g = 0; g < c_qn; g++) begin : g_rom
      assign w_rom[g] = cos_entry(g);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stride sequencer
  // --------------------------------------------------------------------------
  logic [0:0]       r_state;
  logic [LOG2N-1:0] r_acc;
  logic [LOG2N-1:0] r_stride;
  logic [LOG2N:0]   r_rem;
  logic             r_seq_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_acc     <= '0;
      r_stride  <= '0;
      r_rem     <= '0;
      r_seq_inv <= 1'b0;
    end else if (!hold) begin
      case (r_state)
        c_st_idle: begin
          if (start && (count != '0)) begin
            r_state   <= c_st_run;
            r_acc     <= '0;
            r_stride  <= stride;
            r_rem     <= count;
            r_seq_inv <= inv;
          end
        end
        default: begin
          // Accumulator wraps modulo N through its natural width.
          r_acc <= r_acc + r_stride;
          r_rem <= r_rem - (LOG2N + 1)'(1);
          if (r_rem == (LOG2N + 1)'(1)) begin
            r_state <= c_st_idle;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == c_st_run);

  // --------------------------------------------------------------------------
  // Request selection: a running sequence owns the pipeline; otherwise a
  // direct request is taken unless start claims the same cycle.
  // --------------------------------------------------------------------------
  logic             w_req_valid;
  logic [LOG2N-1:0] w_req_k;
  logic             w_req_inv;
  logic [c_rw-1:0]  w_r;
  logic [c_rw-1:0]  w_sidx;

  assign w_req_valid = busy | (in_valid & ~start);
  assign w_req_k     = busy ? r_acc : in_k;
  assign w_req_inv   = busy ? r_seq_inv : inv;
  assign w_r         = w_req_k[c_rw-1:0];
  // sin(r) = C(N/4 - r); for r != 0 that address is simply -r mod N/4.
  assign w_sidx      = -w_r;

  // --------------------------------------------------------------------------
  // Stage 1: address / quadrant decode
  // --------------------------------------------------------------------------
  logic             r1_valid;
  logic [LOG2N-1:0] r1_k;
  logic             r1_inv;
  logic [1:0]       r1_q;
  logic [c_rw-1:0]  r1_ridx;
  logic [c_rw-1:0]  r1_sidx;
  logic             r1_szero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_k     <= '0;
      r1_inv   <= 1'b0;
      r1_q     <= '0;
      r1_ridx  <= '0;
      r1_sidx  <= '0;
      r1_szero <= 1'b0;
    end else if (!hold) begin
      r1_valid <= w_req_valid;
      r1_k     <= w_req_k;
      r1_inv   <= w_req_inv;
      r1_q     <= w_req_k[LOG2N-1:LOG2N-2];
      r1_ridx  <= w_r;
      r1_sidx  <= w_sidx;
      r1_szero <= (w_r == '0);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: dual-port table read
  // --------------------------------------------------------------------------
  logic             r2_valid;
  logic [LOG2N-1:0] r2_k;
  logic             r2_inv;
  logic [1:0]       r2_q;
  logic [FRAC:0]    r2_c;
  logic [FRAC:0]    r2_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_k     <= '0;
      r2_inv   <= 1'b0;
      r2_q     <= '0;
      r2_c     <= '0;
      r2_s     <= '0;
    end else if (!hold) begin
      r2_valid <= r1_valid;
      r2_k     <= r1_k;
      r2_inv   <= r1_inv;
      r2_q     <= r1_q;
      r2_c     <= w_rom[r1_ridx];
      r2_s     <= r1_szero ? '0 : w_rom[r1_sidx];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: quadrant sign selection and conjugation
  // --------------------------------------------------------------------------
  logic signed [FRAC+1:0] w_c;
  logic signed [FRAC+1:0] w_s;
  logic signed [FRAC+1:0] w_cos;
  logic signed [FRAC+1:0] w_sin;
  logic signed [FRAC+1:0] w_im;

  assign w_c = {1'b0, r2_c};
  assign w_s = {1'b0, r2_s};

  always_comb begin
    w_cos = w_c;
    w_sin = w_s;
    case (r2_q)
      2'd0: begin w_cos = w_c;  w_sin = w_s;  end
      2'd1: begin w_cos = -w_s; w_sin = w_c;  end
      2'd2: begin w_cos = -w_c; w_sin = -w_s; end
      default: begin w_cos = w_s; w_sin = -w_c; end
    endcase
  end

  // Forward transform uses the conjugate (cos - j*sin).
  assign w_im = r2_inv ? w_sin : -w_sin;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_k     <= '0;
      out_wr    <= '0;
      out_wi    <= '0;
    end else if (!hold) begin
      out_valid <= r2_valid;
      if (r2_valid) begin
        out_k  <= r2_k;
        out_wr <= DW'(w_cos);
        out_wi <= DW'(w_im);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_twiddle_gen.sv
// ============================================================================
// Module   : tb_twiddle_gen
// Purpose  : Directed self-checking bench for twiddle_gen (N=1024, FRAC=14,
//            DW=16). Inputs change 1 time unit after a rising edge; outputs
//            are read at the same point, so a request driven in iteration i
//            shows up in iteration i+3.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_twiddle_gen;

  localparam int LOG2N = 10;
  localparam int N     = 1 << LOG2N;
  localparam int DW    = 16;
  localparam int FRAC  = 14;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 hold;
  logic                 in_valid;
  logic [LOG2N-1:0]     in_k;
  logic                 inv;
  logic                 start;
  logic [LOG2N-1:0]     stride;
  logic [LOG2N:0]       count;
  logic                 busy;
  logic                 out_valid;
  logic [LOG2N-1:0]     out_k;
  logic signed [DW-1:0] out_wr;
  logic signed [DW-1:0] out_wi;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  twiddle_gen #(.LOG2N(LOG2N), .DW(DW), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_k      (in_k),
    .inv       (inv),
    .start     (start),
    .stride    (stride),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_k     (out_k),
    .out_wr    (out_wr),
    .out_wi    (out_wi)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold     = 1'b0;
    in_valid = 1'b0;
    in_k     = '0;
    inv      = 1'b0;
    start    = 1'b0;
    stride   = '0;
    count    = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_k     = LOG2N'(5);
    start    = 1'b1;
    count    = (LOG2N + 1)'(3);
    repeat (3) step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_k !== '0) begin n_fail++; $display("FAIL reset_k: got %0d want 0", out_k); end
    n_checks++; if (out_wr !== '0) begin n_fail++; $display("FAIL reset_wr: got %0d want 0", out_wr); end
    n_checks++; if (out_wi !== '0) begin n_fail++; $display("FAIL reset_wi: got %0d want 0", out_wi); end
    rst = 1'b0;
    idle_inputs();
    repeat (4) step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_noleak: got %b want 0", out_valid); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_direct();
    int ks[6];
    int ewr[6];
    int ewi[6];
    int j;
    ks  = '{0, 1, 128, 256, 512, 768};
    ewr = '{16384, 16384, 11585, 0, -16384, 0};
    ewi = '{0, -101, -11585, -16384, 0, 16384};
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (out_valid !== ((i >= 3) && (i < 9))) begin
        n_fail++; $display("FAIL direct_valid[%0d]: got %b want %b", i, out_valid, ((i >= 3) && (i < 9)));
      end
      j = (i >= 3) ? ((i < 9) ? i - 3 : 5) : -1;   // last result held after the burst
      if (j >= 0) begin
        n_checks++; if (int'(out_k) !== ks[j]) begin n_fail++; $display("FAIL direct_k[%0d]: got %0d want %0d", i, out_k, ks[j]); end
        n_checks++; if (int'(out_wr) !== ewr[j]) begin n_fail++; $display("FAIL direct_wr k=%0d: got %0d want %0d", ks[j], out_wr, ewr[j]); end
        n_checks++; if (int'(out_wi) !== ewi[j]) begin n_fail++; $display("FAIL direct_wi k=%0d: got %0d want %0d", ks[j], out_wi, ewi[j]); end
      end
      in_valid = (i < 6);
      in_k     = (i < 6) ? LOG2N'(ks[i]) : '0;
      inv      = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_inverse();
    int ks[3];
    int iv[3];
    int ewr[3];
    int ewi[3];
    ks  = '{1, 896, 896};
    iv  = '{1, 1, 0};
    ewr = '{16384, 11585, 11585};
    ewi = '{101, -11585, 11585};
    for (int i = 0; i < 7; i++) begin
      if ((i >= 3) && (i < 6)) begin
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL inv_valid[%0d]: got %b want 1", i, out_valid); end
        n_checks++; if (int'(out_wr) !== ewr[i-3]) begin n_fail++; $display("FAIL inv_wr k=%0d inv=%0d: got %0d want %0d", ks[i-3], iv[i-3], out_wr, ewr[i-3]); end
        n_checks++; if (int'(out_wi) !== ewi[i-3]) begin n_fail++; $display("FAIL inv_wi k=%0d inv=%0d: got %0d want %0d", ks[i-3], iv[i-3], out_wi, ewi[i-3]); end
      end
      in_valid = (i < 3);
      in_k     = (i < 3) ? LOG2N'(ks[i]) : '0;
      inv      = (i < 3) ? iv[i][0] : 1'b0;
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_stride(input int strd, input int cnt);
    int ek;
    for (int i = 0; i < cnt + 6; i++) begin
      n_checks++;
      if (busy !== ((i >= 1) && (i <= cnt))) begin
        n_fail++; $display("FAIL seq_busy s=%0d [%0d]: got %b want %b", strd, i, busy, ((i >= 1) && (i <= cnt)));
      end
      n_checks++;
      if (out_valid !== ((i >= 4) && (i <= cnt + 3))) begin
        n_fail++; $display("FAIL seq_valid s=%0d [%0d]: got %b want %b", strd, i, out_valid, ((i >= 4) && (i <= cnt + 3)));
      end
      if ((i >= 4) && (i <= cnt + 3)) begin
        ek = (strd * (i - 4)) % N;
        n_checks++; if (int'(out_k) !== ek) begin n_fail++; $display("FAIL seq_k s=%0d [%0d]: got %0d want %0d", strd, i, out_k, ek); end
      end
      if (i == 4) begin
        n_checks++; if ((int'(out_wr) !== 16384) || (int'(out_wi) !== 0)) begin
          n_fail++; $display("FAIL seq_w0: got (%0d,%0d) want (16384,0)", out_wr, out_wi);
        end
      end
      start  = (i == 0);
      stride = LOG2N'(strd);
      count  = (LOG2N + 1)'(cnt);
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_count_zero();
    for (int i = 0; i < 7; i++) begin
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cz_busy[%0d]: got %b want 0", i, busy); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL cz_valid[%0d]: got %b want 0", i, out_valid); end
      // start with count 0 still claims the cycle, so the direct request drops
      start    = (i == 0);
      count    = '0;
      stride   = LOG2N'(9);
      in_valid = (i == 0);
      in_k     = LOG2N'(1);
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_busy_ignore();
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (busy !== ((i >= 1) && (i <= 4))) begin
        n_fail++; $display("FAIL bi_busy[%0d]: got %b want %b", i, busy, ((i >= 1) && (i <= 4)));
      end
      n_checks++;
      if (out_valid !== ((i >= 4) && (i <= 7))) begin
        n_fail++; $display("FAIL bi_valid[%0d]: got %b want %b", i, out_valid, ((i >= 4) && (i <= 7)));
      end
      if ((i >= 4) && (i <= 7)) begin
        n_checks++; if (int'(out_k) !== i - 4) begin n_fail++; $display("FAIL bi_k[%0d]: got %0d want %0d", i, out_k, i - 4); end
      end
      start    = (i == 0) || (i == 2);
      stride   = (i == 0) ? LOG2N'(1) : LOG2N'(7);
      count    = (i == 0) ? (LOG2N + 1)'(4) : (LOG2N + 1)'(3);
      in_valid = (i == 2) || (i == 3);
      in_k     = LOG2N'(500);
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hold();
    int e;
    for (int i = 0; i < 15; i++) begin
      // edges sampled while hold=1 (driven in iterations 5 and 6) do not count
      e = i - ((i >= 7) ? 2 : ((i >= 6) ? 1 : 0));
      n_checks++;
      if (busy !== ((e >= 1) && (e <= 6))) begin
        n_fail++; $display("FAIL hold_busy[%0d]: got %b want %b", i, busy, ((e >= 1) && (e <= 6)));
      end
      n_checks++;
      if (out_valid !== ((e >= 4) && (e <= 9))) begin
        n_fail++; $display("FAIL hold_valid[%0d]: got %b want %b", i, out_valid, ((e >= 4) && (e <= 9)));
      end
      if ((e >= 4) && (e <= 9)) begin
        n_checks++; if (int'(out_k) !== 5 * (e - 4)) begin n_fail++; $display("FAIL hold_k[%0d]: got %0d want %0d", i, out_k, 5 * (e - 4)); end
      end
      start  = (i == 0);
      stride = LOG2N'(5);
      count  = (LOG2N + 1)'(6);
      hold   = (i == 5) || (i == 6);
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_rst_mid();
    for (int i = 0; i < 15; i++) begin
      if ((i >= 4) && (i <= 6)) begin
        n_checks++; if ((out_valid !== 1'b1) || (int'(out_k) !== i - 4)) begin
          n_fail++; $display("FAIL rm_pre[%0d]: got v=%b k=%0d want v=1 k=%0d", i, out_valid, out_k, i - 4);
        end
      end
      if (i == 7) begin
        n_checks++; if (out_k !== '0) begin n_fail++; $display("FAIL rm_k: got %0d want 0", out_k); end
        n_checks++; if ((out_wr !== '0) || (out_wi !== '0)) begin n_fail++; $display("FAIL rm_w: got (%0d,%0d) want (0,0)", out_wr, out_wi); end
      end
      if (i >= 7) begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy[%0d]: got %b want 0", i, busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid[%0d]: got %b want 0", i, out_valid); end
      end
      start  = (i == 0);
      stride = LOG2N'(1);
      count  = (LOG2N + 1)'(8);
      rst    = (i == 6);
      step();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_exhaustive();
    int    kk;
    real   ang;
    real   ec;
    real   es;
    real   dr;
    real   di;
    longint mag;
    for (int i = 0; i < N + 4; i++) begin
      if ((i >= 3) && (i < N + 3)) begin
        kk  = i - 3;
        ang = 2.0 * 3.141592653589793 * real'(kk) / real'(N);
        ec  = 16384.0 * $cos(ang);
        es  = -16384.0 * $sin(ang);
        dr  = real'(int'(out_wr)) - ec;
        di  = real'(int'(out_wi)) - es;
        mag = longint'(out_wr) * longint'(out_wr) + longint'(out_wi) * longint'(out_wi);
        n_checks++; if ((out_valid !== 1'b1) || (int'(out_k) !== kk)) begin
          n_fail++; $display("FAIL ex_k: got v=%b k=%0d want v=1 k=%0d", out_valid, out_k, kk);
        end
        n_checks++; if ((dr > 1.0) || (dr < -1.0)) begin
          n_fail++; $display("FAIL ex_wr k=%0d: got %0d want %f", kk, out_wr, ec);
        end
        n_checks++; if ((di > 1.0) || (di < -1.0)) begin
          n_fail++; $display("FAIL ex_wi k=%0d: got %0d want %f", kk, out_wi, es);
        end
        n_checks++; if ((mag > 64'd268500992) || (mag < 64'd268369920)) begin
          n_fail++; $display("FAIL ex_mag k=%0d: got %0d want 268435456 +/- 65536", kk, mag);
        end
      end
      in_valid = (i < N);
      in_k     = LOG2N'(i);
      inv      = 1'b0;
      step();
    end
    idle_inputs();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_direct();
    test_inverse();
    test_stride(3, 5);
    test_stride(300, 5);
    test_count_zero();
    test_busy_ignore();
    test_hold();
    test_rst_mid();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "time limit exceeded");
  end

endmodule

`default_nettype wire

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised full-circle FFT twiddle-factor generator. Stores only a quarter-wave cosine table, derives cos and sin for any index k in 0..N-1 by quadrant symmetry, and returns the signed complex twiddle W = cos(2πk/N) ∓ j·sin(2πk/N) through a 3-stage pipeline. A built-in stride sequencer emits a whole butterfly stage's twiddles (k = 0, s, 2s, … mod N) from a single start pulse. It sits between the FFT control FSM and the butterfly multiplier.

## Interface
- LOG2N, 10, log2 of FFT size N; N ≥ 8
- DW, 16, signed output width; DW ≥ FRAC+2
- FRAC, 14, fractional bits; unity = 2^FRAC

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- hold  in  1  freezes pipeline and sequencer; all state held
- in_valid  in  1  direct request; ignored while busy or start
- in_k  in  LOG2N  direct twiddle index
- inv  in  1  0: W = cos − j·sin (forward), 1: cos + j·sin (inverse); sampled with in_valid or start
- start  in  1  launch sequence; ignored while busy
- stride  in  LOG2N  sequence step, sampled at start
- count  in  LOG2N+1  number of sequence outputs (0..N), sampled at start
- busy  out  1  sequencer active
- out_valid  out  1  result valid
- out_k  out  LOG2N  index belonging to result
- out_wr  out  DW  signed real part
- out_wi  out  DW  signed imaginary part

## Operation
- Table C(i) = round(2^FRAC·cos(2πi/N)), i = 0..N/4−1, built at elaboration; unsigned, FRAC+1 bits. For N=1024, FRAC=14: C(0)=16384, C(1)=16384, C(128)=11585, C(255)=101.
- Split k = {q[1:0], r}, r = k mod N/4. S(r) = C(N/4−r) for r≠0, S(0)=0 (second read port).
- Quadrants: q0: cos=C, sin=S; q1: cos=−S, sin=C; q2: cos=−C, sin=−S; q3: cos=S, sin=−C.
- out_wr = cos; out_wi = −sin if inv=0, +sin if inv=1. Sign-extended to DW; no saturation needed.
- Request source per cycle: sequencer issue if busy; else in_valid. start has priority over in_valid in the same cycle (that in_valid dropped).
- Sequencer states IDLE/RUN. IDLE + start + count≠0 → RUN: latch stride, count, inv; acc = 0. RUN: each non-hold cycle issue k = acc, acc += stride (mod N, wraps naturally), remaining −= 1; after issuing the last, → IDLE. start with count=0: no outputs, stays IDLE.
- busy = 1 in RUN exactly; asserts the cycle after start, deasserts the cycle after final issue.

## Timing
- Latency 3 cycles: request at edge t → out_valid/out_* at edge t+3 (stage 1 address/quadrant decode, stage 2 table read, stage 3 sign/negate register). Throughput 1/cycle.
- hold=1: no stage advances, outputs and busy held, request inputs that cycle ignored.
- Reset: busy=0, out_valid=0, out_k=0, out_wr=0, out_wi=0, all pipeline valids 0, state IDLE. Reset mid-sequence aborts; in-flight results discarded.
- Sequence of count=M produces out_valid high for exactly M consecutive non-hold cycles, first at 4 cycles after start edge.
- out_* hold last value when out_valid=0.

## Test plan
- Direct, inv=0, N=1024: k=0,1,128,256,512,768 back-to-back → (16384,0),(16384,−101),(11585,−11585),(0,−16384),(−16384,0),(0,16384) on 6 consecutive cycles starting 3 cycles later.
- inv=1, k=1 and k=896 → (16384,+101), (11585,−11585); inv=0 k=896 → (11585,+11585).
- start, stride=3, count=5 → out_k 0,3,6,9,12 consecutive; busy high 5 cycles; stride=300, count=5 → out_k 0,300,600,900,176 (wrap).
- count=0 start → no out_valid, busy stays 0; start while busy and in_valid while busy ignored.
- hold asserted 2 cycles mid-sequence → outputs frozen, no index skipped or duplicated; rst mid-sequence → busy and out_valid 0 next cycle, no stale results.
- Exhaustive k=0..N−1 vs real-valued model: |error| ≤ 1 LSB, and out_wr² + out_wi² within 2^(2FRAC) ± 2^(FRAC+2).
